// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and shared single-port memory bus.
// The arbiter connects through the slave modport; the requesters/memory side uses master.
`default_nettype none

interface mem_arbiter_if;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_done;
  logic        fetch_stall;

  logic        m_rd;
  logic        m_wr;
  logic [15:0] m_addr;
  logic [15:0] m_wdata;
  logic [15:0] m_rdata;
  logic        m_done;
  logic        mem_stall;
  logic        m_err;

  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, m_rd, m_wr, m_addr, m_wdata, mem_ack, mem_rdata,
    output if_rdata, if_done, fetch_stall, m_rdata, m_done, mem_stall, m_err,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, m_rd, m_wr, m_addr, m_wdata, mem_ack, mem_rdata,
    input  if_rdata, if_done, fetch_stall, m_rdata, m_done, mem_stall, m_err,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-port memory.
// Data wins in IDLE unless fetch has been passed over STARVE_LIMIT times in a row.
`default_nettype none

module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  wire logic     clk,
  input  wire logic     rst,
  mem_arbiter_if.slave  bus
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_IF_BUSY = 2'd1;
  localparam logic [1:0] S_M_BUSY  = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_M  = 1'b1;

  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic             owner;
  logic [15:0]      cap_addr;
  logic [15:0]      cap_wdata;
  logic             cap_we;
  logic             cap_err;
  logic [CNT_W-1:0] starve_cnt;
  logic [15:0]      if_rdata_q;
  logic [15:0]      m_rdata_q;

  logic data_pend;
  logic starve_hit;
  logic grant_if;
  logic grant_m;
  logic busy;

  assign data_pend  = bus.m_rd | bus.m_wr;
  assign starve_hit = (starve_cnt == CNT_MAX);
  assign grant_m    = (state == S_IDLE) && data_pend && !(bus.if_req && starve_hit);
  assign grant_if   = (state == S_IDLE) && bus.if_req && (!data_pend || starve_hit);
  assign busy       = (state == S_IF_BUSY) || (state == S_M_BUSY);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (grant_m) begin
          state_nx = S_M_BUSY;
        end else if (grant_if) begin
          state_nx = S_IF_BUSY;
        end
      end
      S_IF_BUSY, S_M_BUSY: begin
        if (bus.mem_ack) begin
          state_nx = S_RESP;
        end
      end
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Grant capture; a simultaneous read+write request is executed as a write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner     <= OWN_IF;
      cap_addr  <= 16'h0000;
      cap_wdata <= 16'h0000;
      cap_we    <= 1'b0;
      cap_err   <= 1'b0;
    end else if (grant_m) begin
      owner     <= OWN_M;
      cap_addr  <= bus.m_addr;
      cap_wdata <= bus.m_wdata;
      cap_we    <= bus.m_wr;
      cap_err   <= bus.m_rd & bus.m_wr;
    end else if (grant_if) begin
      owner     <= OWN_IF;
      cap_addr  <= bus.if_addr;
      cap_we    <= 1'b0;
      cap_err   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (grant_m) begin
      if (!bus.if_req) begin
        starve_cnt <= '0;
      end else if (!starve_hit) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end else if (grant_if) begin
      starve_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rdata_q <= 16'h0000;
      m_rdata_q  <= 16'h0000;
    end else if (bus.mem_ack) begin
      if (state == S_IF_BUSY) begin
        if_rdata_q <= bus.mem_rdata;
      end else if ((state == S_M_BUSY) && !cap_we) begin
        m_rdata_q <= bus.mem_rdata;
      end
    end
  end

  always_comb begin
    bus.mem_req   = busy;
    bus.mem_we    = busy & cap_we;
    bus.mem_addr  = cap_addr;
    bus.mem_wdata = cap_wdata;
    bus.if_done   = (state == S_RESP) && (owner == OWN_IF);
    bus.m_done    = (state == S_RESP) && (owner == OWN_M);
    bus.m_err     = (state == S_RESP) && (owner == OWN_M) && cap_err;
  end

  assign bus.if_rdata    = if_rdata_q;
  assign bus.m_rdata     = m_rdata_q;
  assign bus.fetch_stall = bus.if_req & ~bus.if_done;
  assign bus.mem_stall   = data_pend & ~bus.m_done;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected memory accesses and completions are queued
// by the stimulus; a memory model and a completion monitor pop and compare them.
`default_nettype none

module tb_mem_arbiter;

  typedef struct {
    logic        port;
    logic [15:0] data;
    logic        err;
  } done_t;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } acc_t;

  localparam logic P_IF = 1'b0;
  localparam logic P_M  = 1'b1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  mem_arbiter_if bus();

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int ack_delay = 1;

  done_t dq[$];
  acc_t  aq[$];
  logic [15:0] mem [logic [15:0]];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_acc(input logic we, input logic [15:0] a, input logic [15:0] wd);
    acc_t e;
    e.we = we; e.addr = a; e.wdata = wd;
    aq.push_back(e);
  endtask

  task automatic push_done(input logic p, input logic [15:0] d, input logic err);
    done_t e;
    e.port = p; e.data = d; e.err = err;
    dq.push_back(e);
  endtask

  task automatic do_fetch(input logic [15:0] a, input bit chk_starve);
    bit seen;
    seen = 1'b0;
    bus.if_addr = a;
    bus.if_req  = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (bus.if_done) begin
        seen = 1'b1;
        chk("fetch_stall_done", 16'(bus.fetch_stall), 16'h0);
        if (chk_starve) chk("starve_cnt_after_fetch", 16'(dut.starve_cnt), 16'h0);
        break;
      end
      chk("fetch_stall_wait", 16'(bus.fetch_stall), 16'h1);
    end
    if (!seen) fail_now("fetch_timeout");
    bus.if_req = 1'b0;
  endtask

  task automatic do_data(input logic rd, input logic wr, input logic [15:0] a,
                         input logic [15:0] wd, input int n, output int lat);
    int got;
    int cyc;
    got = 0;
    cyc = 1;
    lat = 0;
    bus.m_addr  = a;
    bus.m_wdata = wd;
    bus.m_rd    = rd;
    bus.m_wr    = wr;
    for (int i = 0; i < 400 && got < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.m_done) begin
        got++;
        if (got == 1) lat = cyc;
        chk("mem_stall_done", 16'(bus.mem_stall), 16'h0);
      end else begin
        chk("mem_stall_wait", 16'(bus.mem_stall), 16'h1);
      end
    end
    if (got < n) fail_now("data_timeout");
    bus.m_rd = 1'b0;
    bus.m_wr = 1'b0;
  endtask

  // Memory model: acks ack_delay cycles after the first mem_req cycle of an access.
  initial begin
    bit          in_acc;
    int          wcnt;
    acc_t        cur;
    acc_t        e;
    in_acc = 1'b0;
    wcnt = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 16'h0000;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        bus.mem_ack = 1'b0;
        in_acc = 1'b0;
        wcnt = 0;
      end else if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
        in_acc = 1'b0;
      end else if (bus.mem_req) begin
        if (!in_acc) begin
          in_acc = 1'b1;
          wcnt = 0;
          cur.we = bus.mem_we; cur.addr = bus.mem_addr; cur.wdata = bus.mem_wdata;
          if (aq.size() == 0) begin
            fail_now("unexpected_mem_access");
          end else begin
            e = aq.pop_front();
            chk("acc_we", 16'(bus.mem_we), 16'(e.we));
            chk("acc_addr", bus.mem_addr, e.addr);
            if (e.we) chk("acc_wdata", bus.mem_wdata, e.wdata);
          end
        end else begin
          chk("hold_addr", bus.mem_addr, cur.addr);
          chk("hold_we", 16'(bus.mem_we), 16'(cur.we));
        end
        if (wcnt == ack_delay) begin
          bus.mem_ack = 1'b1;
          if (cur.we) begin
            mem[cur.addr] = cur.wdata;
          end else begin
            bus.mem_rdata = mem.exists(cur.addr) ? mem[cur.addr] : 16'hDEAD;
          end
        end else begin
          wcnt++;
        end
      end
    end
  end

  // Completion monitor
  initial begin
    done_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (bus.m_err && !bus.m_done) fail_now("m_err_without_done");
        if (bus.if_done && bus.m_done) fail_now("both_done");
        if (bus.if_done || bus.m_done) begin
          if (dq.size() == 0) begin
            fail_now("unexpected_done");
          end else begin
            e = dq.pop_front();
            chk("done_port", 16'(bus.m_done), 16'(e.port));
            if (e.port == P_IF) begin
              chk("if_rdata", bus.if_rdata, e.data);
            end else begin
              chk("m_rdata", bus.m_rdata, e.data);
              chk("m_err", 16'(bus.m_err), 16'(e.err));
            end
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bus.if_req = 1'b0; bus.if_addr = 16'h0;
    bus.m_rd = 1'b0; bus.m_wr = 1'b0; bus.m_addr = 16'h0; bus.m_wdata = 16'h0;
    mem[16'h0010] = 16'hA5A5;
    mem[16'h0020] = 16'h1111;
    mem[16'h0100] = 16'hBEEF;

    #3;
    chk("rst_mem_req", 16'(bus.mem_req), 16'h0);
    chk("rst_mem_we", 16'(bus.mem_we), 16'h0);
    chk("rst_if_done", 16'(bus.if_done), 16'h0);
    chk("rst_m_done", 16'(bus.m_done), 16'h0);
    chk("rst_m_err", 16'(bus.m_err), 16'h0);
    chk("rst_mem_addr", bus.mem_addr, 16'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 16'h0);
    chk("rst_if_rdata", bus.if_rdata, 16'h0);
    chk("rst_m_rdata", bus.m_rdata, 16'h0);
    idle(2);
    rst = 1'b1;
    idle(2);

    // Fetch only
    push_acc(1'b0, 16'h0010, 16'h0);
    push_done(P_IF, 16'hA5A5, 1'b0);
    do_fetch(16'h0010, 1'b0);
    idle(2);

    // Simultaneous write + fetch: write goes first, m_rdata untouched
    push_acc(1'b1, 16'h0040, 16'h1234);
    push_acc(1'b0, 16'h0010, 16'h0);
    push_done(P_M, 16'h0000, 1'b0);
    push_done(P_IF, 16'hA5A5, 1'b0);
    fork
      do_fetch(16'h0010, 1'b0);
      do_data(1'b0, 1'b1, 16'h0040, 16'h1234, 1, lat);
    join
    idle(2);

    // Starvation: 4 data grants, then fetch, then remaining data read
    for (int i = 0; i < 4; i++) push_acc(1'b0, 16'h0100, 16'h0);
    push_acc(1'b0, 16'h0020, 16'h0);
    push_acc(1'b0, 16'h0100, 16'h0);
    for (int i = 0; i < 4; i++) push_done(P_M, 16'hBEEF, 1'b0);
    push_done(P_IF, 16'h1111, 1'b0);
    push_done(P_M, 16'hBEEF, 1'b0);
    fork
      do_fetch(16'h0020, 1'b1);
      do_data(1'b1, 1'b0, 16'h0100, 16'h0, 5, lat);
    join
    idle(2);

    // Read+write together: executes as a write, m_err with m_done, minimum latency
    ack_delay = 0;
    push_acc(1'b1, 16'h0050, 16'h5555);
    push_done(P_M, 16'hBEEF, 1'b1);
    do_data(1'b1, 1'b1, 16'h0050, 16'h5555, 1, lat);
    idle(2);
    push_acc(1'b0, 16'h0050, 16'h0);
    push_done(P_M, 16'h5555, 1'b0);
    do_data(1'b1, 1'b0, 16'h0050, 16'h0, 1, lat);
    chk("min_latency", 16'(lat), 16'd3);
    idle(2);

    // Reset during M_BUSY abandons the read; pending fetch then completes
    ack_delay = 5;
    push_acc(1'b0, 16'h0060, 16'h0);
    bus.m_addr = 16'h0060; bus.m_rd = 1'b1;
    bus.if_addr = 16'h0010; bus.if_req = 1'b1;
    idle(2);
    chk("busy_mem_req", 16'(bus.mem_req), 16'h1);
    chk("busy_mem_addr", bus.mem_addr, 16'h0060);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("async_rst_mem_req", 16'(bus.mem_req), 16'h0);
    chk("async_rst_m_rdata", bus.m_rdata, 16'h0);
    chk("async_rst_if_rdata", bus.if_rdata, 16'h0);
    chk("async_rst_mem_addr", bus.mem_addr, 16'h0);
    bus.m_rd = 1'b0;
    ack_delay = 1;
    push_acc(1'b0, 16'h0010, 16'h0);
    push_done(P_IF, 16'hA5A5, 1'b0);
    idle(1);
    rst = 1'b1;
    do_fetch(16'h0010, 1'b0);
    idle(4);

    chk("acc_queue_empty", 16'(aq.size()), 16'h0);
    chk("done_queue_empty", 16'(dq.size()), 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
